// File: rtl/pip_pkg.sv
// -----------------------------------------------------------------------------
// pip_pkg
// Shared definitions for the elastic pipeline stage register:
//   pip_state_e - occupancy state of a stage (empty / main only / main + skid)
//   PIP_CTRL_W  - default control payload width used by stage instantiations
//   PIP_DATA_W  - default data payload width used by stage instantiations
// -----------------------------------------------------------------------------
package pip_pkg;

  typedef enum logic [1:0] {
    PIP_EMPTY = 2'd0,  // no valid entry
    PIP_FULL  = 2'd1,  // main entry valid
    PIP_SKID  = 2'd2   // main and skid entries valid
  } pip_state_e;

  localparam int PIP_CTRL_W = 16;
  localparam int PIP_DATA_W = 64;

endpackage : pip_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter for performance statistics. Counts cycles with inc_i
// high, sticks at all-ones instead of wrapping. Clear beats increment.
// Ports:
//   clk_i    in  1      clock, rising edge
//   rst_i    in  1      synchronous active-high reset (count -> 0)
//   clr_i    in  1      synchronous clear (count -> 0), priority over inc_i
//   inc_i    in  1      increment request
//   count_o  out WIDTH  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_max;

  assign at_max = &count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !at_max) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: state registers are written with <= so every flop samples the
  // pre-edge values; a blocking = here would create ordering races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/pip_reg_elastic.sv
// -----------------------------------------------------------------------------
// pip_reg_elastic
// Generic valid/ready pipeline stage register with a two-entry skid buffer.
// ready_o comes straight from the state flop, so downstream back-pressure never
// forms a combinational path to the upstream stage. Control and data payloads
// are kept separate: a flush turns the stage into a bubble by clearing valid and
// control, and clears data only when CLEAR_DATA=1.
// Ports:
//   clk_i            in  1           clock, rising edge
//   rst_i            in  1           synchronous active-high reset
//   flush_i          in  1           synchronous flush (drops held and incoming items)
//   valid_i          in  1           upstream item valid
//   ready_o          out 1           stage accepts an item this cycle (registered)
//   ctrl_i           in  CTRL_WIDTH  upstream control payload
//   data_i           in  DATA_WIDTH  upstream data payload
//   valid_o          out 1           downstream item valid
//   ready_i          in  1           downstream accepts this cycle
//   ctrl_o           out CTRL_WIDTH  control payload, zero while valid_o=0
//   data_o           out DATA_WIDTH  data payload of the main entry
//   stall_cnt_o      out CNT_WIDTH   saturating count of valid_o & ~ready_i cycles
//   stall_cnt_clr_i  in  1           synchronous clear of the stall counter
// -----------------------------------------------------------------------------
module pip_reg_elastic
  import pip_pkg::*;
#(
  parameter int DATA_WIDTH = PIP_DATA_W,
  parameter int CTRL_WIDTH = PIP_CTRL_W,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  input  logic                  stall_cnt_clr_i
);

  pip_state_e            state_q,     state_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  logic in_fire;
  logic out_fire;

  assign ready_o  = (state_q != PIP_SKID);
  assign valid_o  = (state_q != PIP_EMPTY);
  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  // ---------------------------------------------------------------------------
  // Next-state and entry update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush_i) begin
      // Bubble: a coincident out_fire was already taken downstream this edge,
      // a coincident in_fire is simply not captured.
      state_d     = PIP_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        PIP_EMPTY: begin
          if (in_fire) begin
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
            state_d     = PIP_FULL;
          end
        end
        PIP_FULL: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = ctrl_i;
            main_data_d = data_i;
          end else if (in_fire) begin
            // Downstream stalled after ready_o was already promised: park the
            // new item in the skid entry.
            skid_ctrl_d = ctrl_i;
            skid_data_d = data_i;
            state_d     = PIP_SKID;
          end else if (out_fire) begin
            state_d = PIP_EMPTY;
          end
        end
        PIP_SKID: begin
          if (out_fire) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = PIP_FULL;
          end
        end
        default: state_d = PIP_EMPTY;
      endcase
    end
  end

  // NOTE: the payload entries sit in the reset branch on purpose: outputs must
  // read zero right after reset, so these are not left as reset-free storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= PIP_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Control is gated by occupancy so a bubble never carries live control bits.
  assign ctrl_o = valid_o ? main_ctrl_q : '0;
  assign data_o = main_data_q;

  // ---------------------------------------------------------------------------
  // Stall statistics (independent of flush)
  // ---------------------------------------------------------------------------
  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (stall_cnt_clr_i),
    .inc_i   (valid_o & ~ready_i),
    .count_o (stall_cnt_o)
  );

endmodule : pip_reg_elastic

// File: tb/tb_pip_reg_elastic.sv
// -----------------------------------------------------------------------------
// tb_pip_reg_elastic
// Two stage instances driven with identical stimulus:
//   dut_k : CLEAR_DATA=0, CNT_WIDTH=16 (data kept on flush)
//   dut_c : CLEAR_DATA=1, CNT_WIDTH=4  (data cleared on flush, small counter)
// Table-driven vectors cover streaming, back-pressure and flush; hand-written
// sequences cover stall-counter saturation/clear and reset in SKID.
// -----------------------------------------------------------------------------
module tb_pip_reg_elastic;
  import pip_pkg::*;

  localparam int CW = PIP_CTRL_W;
  localparam int DW = PIP_DATA_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          valid_i;
  logic          ready_i;
  logic [CW-1:0] ctrl_i;
  logic [DW-1:0] data_i;
  logic          stall_clr;

  logic          ready_k, valid_k, ready_c, valid_c;
  logic [CW-1:0] ctrl_k, ctrl_c;
  logic [DW-1:0] data_k, data_c;
  logic [15:0]   cnt_k;
  logic [3:0]    cnt_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pip_reg_elastic #(
    .DATA_WIDTH (DW), .CTRL_WIDTH (CW), .CLEAR_DATA (1'b0), .CNT_WIDTH (16)
  ) dut_k (
    .clk_i (clk), .rst_i (rst), .flush_i (flush), .valid_i (valid_i),
    .ready_o (ready_k), .ctrl_i (ctrl_i), .data_i (data_i), .valid_o (valid_k),
    .ready_i (ready_i), .ctrl_o (ctrl_k), .data_o (data_k),
    .stall_cnt_o (cnt_k), .stall_cnt_clr_i (stall_clr)
  );

  pip_reg_elastic #(
    .DATA_WIDTH (DW), .CTRL_WIDTH (CW), .CLEAR_DATA (1'b1), .CNT_WIDTH (4)
  ) dut_c (
    .clk_i (clk), .rst_i (rst), .flush_i (flush), .valid_i (valid_i),
    .ready_o (ready_c), .ctrl_i (ctrl_i), .data_i (data_i), .valid_o (valid_c),
    .ready_i (ready_i), .ctrl_o (ctrl_c), .data_o (data_c),
    .stall_cnt_o (cnt_c), .stall_cnt_clr_i (stall_clr)
  );

  typedef struct {
    logic          valid;
    logic          ready;
    logic          flush;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          e_valid;
    logic          e_ready;
    logic [CW-1:0] e_ctrl;
    logic [DW-1:0] e_data_k;
    logic [DW-1:0] e_data_c;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic r, input logic f,
                     input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input logic ev, input logic er, input logic [CW-1:0] ec,
                     input logic [DW-1:0] edk, input logic [DW-1:0] edc);
    vec_t t;
    t.valid = v; t.ready = r; t.flush = f; t.ctrl = c; t.data = d;
    t.e_valid = ev; t.e_ready = er; t.e_ctrl = ec; t.e_data_k = edk; t.e_data_c = edc;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic r, input logic f,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    valid_i = v; ready_i = r; flush = f; ctrl_i = c; data_i = d;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].valid, vecs[i].ready, vecs[i].flush, vecs[i].ctrl, vecs[i].data);
      step();
      check($sformatf("v%0d valid_k", i), 64'(valid_k), 64'(vecs[i].e_valid));
      check($sformatf("v%0d ready_k", i), 64'(ready_k), 64'(vecs[i].e_ready));
      check($sformatf("v%0d ctrl_k",  i), 64'(ctrl_k),  64'(vecs[i].e_ctrl));
      check($sformatf("v%0d data_k",  i), data_k,       vecs[i].e_data_k);
      check($sformatf("v%0d valid_c", i), 64'(valid_c), 64'(vecs[i].e_valid));
      check($sformatf("v%0d ready_c", i), 64'(ready_c), 64'(vecs[i].e_ready));
      check($sformatf("v%0d ctrl_c",  i), 64'(ctrl_c),  64'(vecs[i].e_ctrl));
      check($sformatf("v%0d data_c",  i), data_c,       vecs[i].e_data_c);
    end
  endtask

  initial begin
    rst = 1'b1; stall_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);

    // ---- vector table --------------------------------------------------------
    // Streaming rows 0..8: items 1..8 back to back, then drain.
    for (int i = 1; i <= 8; i++)
      add(1, 1, 0, CW'(16'h0100 + i), DW'(i), 1, 1, CW'(16'h0100 + i), DW'(i), DW'(i));
    add(0, 1, 0, '0, '0, 0, 1, '0, 64'd8, 64'd8);
    // Back-pressure rows 9..14: A lands, B goes to skid, C waits upstream.
    add(1, 1, 0, 16'h0A0A, 64'hA, 1, 1, 16'h0A0A, 64'hA, 64'hA);
    add(1, 0, 0, 16'h0B0B, 64'hB, 1, 0, 16'h0A0A, 64'hA, 64'hA);
    add(1, 0, 0, 16'h0C0C, 64'hC, 1, 0, 16'h0A0A, 64'hA, 64'hA);
    add(1, 1, 0, 16'h0C0C, 64'hC, 1, 1, 16'h0B0B, 64'hB, 64'hB);
    add(1, 1, 0, 16'h0C0C, 64'hC, 1, 1, 16'h0C0C, 64'hC, 64'hC);
    add(0, 1, 0, '0, '0, 0, 1, '0, 64'hC, 64'hC);
    // Flush in SKID rows 15..18: coincident item 7 must be dropped.
    add(1, 0, 0, 16'h00FF, 64'd5, 1, 1, 16'h00FF, 64'd5, 64'd5);
    add(1, 0, 0, 16'h0F0F, 64'd6, 1, 0, 16'h00FF, 64'd5, 64'd5);
    add(1, 0, 1, 16'h1234, 64'd7, 0, 1, '0, 64'd5, 64'd0);
    add(0, 1, 0, '0, '0, 0, 1, '0, 64'd5, 64'd0);
    // Flush with simultaneous in_fire and out_fire rows 19..21.
    add(1, 1, 0, 16'h0011, 64'h11, 1, 1, 16'h0011, 64'h11, 64'h11);
    add(1, 1, 1, 16'h0022, 64'h22, 0, 1, '0, 64'h11, 64'h0);
    add(0, 1, 0, '0, '0, 0, 1, '0, 64'h11, 64'h0);

    // ---- reset state ---------------------------------------------------------
    step(); step();
    rst = 1'b0;
    check("rst valid_k", 64'(valid_k), 64'd0);
    check("rst ready_k", 64'(ready_k), 64'd1);
    check("rst ctrl_k",  64'(ctrl_k),  64'd0);
    check("rst data_k",  data_k,       64'd0);
    check("rst cnt_k",   64'(cnt_k),   64'd0);
    check("rst ready_c", 64'(ready_c), 64'd1);

    // ---- table-driven sections -------------------------------------------------
    apply(0, 8);
    check("stream cnt_k", 64'(cnt_k), 64'd0);
    apply(9, 14);
    check("bp cnt_k", 64'(cnt_k), 64'd2);
    check("bp cnt_c", 64'(cnt_c), 64'd2);
    apply(15, 18);
    apply(19, 21);
    check("flush cnt_k", 64'(cnt_k), 64'd4);
    check("flush cnt_c", 64'(cnt_c), 64'd4);

    // ---- stall counter saturation and clear ------------------------------------
    stall_clr = 1'b1;
    drive(0, 1, 0, '0, '0);
    step();
    stall_clr = 1'b0;
    check("clr cnt_k", 64'(cnt_k), 64'd0);
    check("clr cnt_c", 64'(cnt_c), 64'd0);
    drive(1, 1, 0, 16'h0033, 64'h33);
    step();
    drive(0, 0, 0, '0, '0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 15) begin
        check("sat15 cnt_k", 64'(cnt_k), 64'd15);
        check("sat15 cnt_c", 64'(cnt_c), 64'd15);
      end
    end
    check("sat20 cnt_k", 64'(cnt_k), 64'd20);
    check("sat20 cnt_c", 64'(cnt_c), 64'd15);
    check("stall hold data_k", data_k, 64'h33);
    check("stall hold ctrl_c", 64'(ctrl_c), 64'h33);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    check("clr over inc cnt_k", 64'(cnt_k), 64'd0);
    check("clr over inc cnt_c", 64'(cnt_c), 64'd0);

    // ---- reset in SKID ----------------------------------------------------------
    drive(1, 0, 0, 16'h0044, 64'h44);
    step();
    check("skid ready_k", 64'(ready_k), 64'd0);
    check("skid data_k",  data_k,       64'h33);
    check("skid cnt_k",   64'(cnt_k),   64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid rst valid_k", 64'(valid_k), 64'd0);
    check("mid rst ready_k", 64'(ready_k), 64'd1);
    check("mid rst ctrl_k",  64'(ctrl_k),  64'd0);
    check("mid rst data_k",  data_k,       64'd0);
    check("mid rst cnt_k",   64'(cnt_k),   64'd0);
    check("mid rst data_c",  data_c,       64'd0);
    drive(1, 1, 0, 16'h0055, 64'h55);
    step();
    drive(0, 1, 0, '0, '0);
    check("post rst valid_k", 64'(valid_k), 64'd1);
    check("post rst ctrl_k",  64'(ctrl_k),  64'h55);
    check("post rst data_k",  data_k,       64'h55);
    step();
    check("post rst drain valid_k", 64'(valid_k), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pip_reg_elastic

// File: doc/pip_reg_elastic.md
Name: pip_reg_elastic

Overview:
- Generic, parametrised pipeline stage register that replaces the per-stage hand-written registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Uses a valid/ready handshake with a two-entry skid buffer, so `ready_o` is driven from a flop and back-pressure does not form a combinational path across stages.
- Control and data fields are separate. Flush kills only valid and control (a bubble), and optionally clears data.
- A saturating stall counter supports performance analysis.

Parameters:
- DATA_WIDTH, 64, width of datapath payload (operands, PC, immediates, register addresses).
- CTRL_WIDTH, 16, width of control payload (RegWrite, MemWrite, Jump, Branch, ALU control, ...); forced to zero whenever the stage holds a bubble.
- CLEAR_DATA, 0, 1: data entries are zeroed on flush/reset; 0: data entries retain their value on flush (zeroed only on reset).
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  synchronous flush (branch mispredict / hazard bubble)
- valid_i  in  1  upstream item valid
- ready_o  out  1  stage can accept an item this cycle (registered)
- ctrl_i  in  CTRL_WIDTH  upstream control payload
- data_i  in  DATA_WIDTH  upstream data payload
- valid_o  out  1  downstream item valid
- ready_i  in  1  downstream accepts this cycle
- ctrl_o  out  CTRL_WIDTH  control payload; zero whenever valid_o=0
- data_o  out  DATA_WIDTH  data payload of the main entry
- stall_cnt_o  out  CNT_WIDTH  saturating count of cycles with valid_o=1 and ready_i=0
- stall_cnt_clr_i  in  1  synchronous clear of stall_cnt_o

Behaviour:
- Storage is a main entry (drives the outputs) and a skid entry. The state register has three states:
  - EMPTY: no valid entry.
  - FULL: main entry valid.
  - SKID: main and skid entries both valid.
- Handshake definitions:
  - in_fire = valid_i & ready_o.
  - out_fire = valid_o & ready_i.
- Output mapping:
  - ready_o = (state != SKID).
  - valid_o = (state != EMPTY).
  - ctrl_o = main ctrl gated by valid_o.
- Transitions when no reset or flush is active:
  - EMPTY + in_fire: load main, go to FULL.
  - FULL + in_fire + out_fire: load main, stay FULL.
  - FULL + in_fire without out_fire: load skid, go to SKID.
  - FULL + out_fire only: go to EMPTY.
  - SKID + out_fire: move skid to main, go to FULL. valid_i is ignored because ready_o=0.
  - SKID without out_fire: hold.
- Latency and throughput:
  - One cycle from in_fire to valid_o.
  - Full throughput: one item per cycle while ready_i stays high.
  - No item is lost or duplicated.
- Priority order: rst_i, then flush_i, then the handshake.
- On rst_i:
  - State goes to EMPTY.
  - Both ctrl entries and both data entries are cleared to 0.
  - stall_cnt_o is cleared to 0.
  - Next cycle: valid_o=0, ready_o=1, ctrl_o=0, data_o=0.
- On flush_i:
  - State goes to EMPTY, and both ctrl entries are cleared.
  - Data entries are cleared if CLEAR_DATA=1; otherwise they hold.
  - A coincident in_fire item is dropped.
  - A coincident out_fire still counts as delivered downstream, because it is sampled in the same edge.
  - Flushing in SKID state discards both items.
- Flush while empty: no effect apart from the CLEAR_DATA clear.
- Stall counter:
  - Increments when valid_o & ~ready_i.
  - Saturates at all-ones and does not wrap.
  - stall_cnt_clr_i has priority over increment.
  - The counter is unaffected by flush_i.
- Stability rules:
  - While valid_o=1 and ready_i=0, ctrl_o and data_o hold stable until out_fire or flush.
  - No output depends combinationally on any input, except ctrl_o gating by internal state only.
- Reset mid-transfer drops all held items. Upstream must re-issue; this is guaranteed by the pipeline restart.

Decomposition:
- Shared package pip_pkg holds:
  - the state enum pip_state_e {PIP_EMPTY, PIP_FULL, PIP_SKID}, 2 bits;
  - the default width constants (PIP_CTRL_W, PIP_DATA_W) used by the stage instantiations.
- One sub-module, sat_counter (parameter WIDTH; ports clk_i, rst_i, clr_i, inc_i, count_o), for the stall counter. It is reusable for other perf counters.
- The skid datapath stays inline.

Test Plan:
- Streaming: ready_i=1 constantly, valid_i=1 with data 1..8 -> valid_o goes high one cycle later, data_o 1..8 in order, ready_o stays 1, stall_cnt_o=0.
- Back-pressure: feed A, B, C; ready_i=0 from the cycle after A lands -> state SKID holding A (main) and B (skid), ready_o=0, C is held upstream. Raise ready_i -> outputs A, B, C in order with none lost. stall_cnt_o equals the low-ready cycles while valid_o=1.
- Flush in SKID, CLEAR_DATA=0: entries ctrl=16'h00FF/data=5 and ctrl=16'h0F0F/data=6, assert flush_i one cycle -> next cycle valid_o=0, ctrl_o=0, data_o=5, ready_o=1; a coincident valid_i item is dropped.
- Flush with CLEAR_DATA=1 plus simultaneous in_fire and out_fire -> out item is consumed downstream; next cycle state EMPTY, data_o=0, ctrl_o=0.
- Saturation: CNT_WIDTH=4, hold valid_o=1, ready_i=0 for 20 cycles -> stall_cnt_o reaches 15 and stays. Pulse stall_cnt_clr_i together with a stall -> 0.
- Reset mid-operation: rst_i asserted in SKID -> next cycle all outputs 0, ready_o=1, stall_cnt_o=0; the first post-reset item passes with one-cycle latency.
